// File: rtl/pvr_vtx_f2f_seq_pkg.sv
// pvr_f2f_pkg: shared types and constants for the PVR vertex float-to-fixed
// sequencer (pvr_vtx_f2f_seq) and its conversion stage (pvr_f2f_stage).
//   state_e        : sequencer states
//   C_X..C_V       : component indices, also the result slot / out_exc bit index
//   EXP_ZERO/SPECIAL: IEEE-754 single exponent codes that get special handling
//   frac_for_idx() : picks the fraction-bit count for a component
package pvr_f2f_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DRAIN, DONE} state_e;

  localparam logic [2:0] C_X = 3'd0;
  localparam logic [2:0] C_Y = 3'd1;
  localparam logic [2:0] C_Z = 3'd2;
  localparam logic [2:0] C_U = 3'd3;
  localparam logic [2:0] C_V = 3'd4;

  localparam logic [7:0] EXP_ZERO    = 8'd0;
  localparam logic [7:0] EXP_SPECIAL = 8'd255;

  function automatic logic [5:0] frac_for_idx(input logic [2:0] idx,
                                              input logic [5:0] frac_xy,
                                              input logic [5:0] frac_z,
                                              input logic [5:0] frac_uv);
    case (idx)
      C_X, C_Y: return frac_xy;
      C_Z:      return frac_z;
      default:  return frac_uv;
    endcase
  endfunction

endpackage

// File: rtl/pvr_vtx_f2f_seq_if.sv
// pvr_vtx_f2f_seq_if: vertex-in / fixed-vertex-out handshake bundle.
//   in_valid/in_ready, in_x..in_v   : float vertex from the TA parser
//   out_valid/out_ready, out_x..out_v, out_exc : fixed vertex to raster setup
//   busy                            : sequencer not idle
// Modports: master = vertex producer + result consumer, slave = sequencer.
interface pvr_vtx_f2f_seq_if #(
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x, in_y, in_z, in_u, in_v;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_x, out_y, out_z, out_u, out_v;
  logic [4:0]       out_exc;
  logic             busy;

  modport master (
    output in_valid, in_x, in_y, in_z, in_u, in_v, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_u, out_v, out_exc, busy
  );

  modport slave (
    input  in_valid, in_x, in_y, in_z, in_u, in_v, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_u, out_v, out_exc, busy
  );
endinterface

// File: rtl/pvr_vtx_f2f_seq_stage.sv
// float_to_fixed : combinational IEEE-754 single -> 48-bit signed fixed point
//                  with i_frac fraction bits; truncates toward zero, and
//                  saturates to the 48-bit signed range when the magnitude
//                  cannot fit.
// pvr_f2f_stage  : shared converter plus the tagged 48-bit result register.
//   i_valid/i_idx/i_flt/i_frac : component issued this cycle
//   o_valid/o_tag/o_data/o_exc : registered result ready for slot write-back
// Optional: PVR_F2F_CLAMP_EN saturates results to OUT_W bits on write-back.
module float_to_fixed (
  input  logic [31:0]        i_flt,
  input  logic [5:0]         i_frac,
  output logic signed [47:0] o_fix
);
  logic [23:0]        w_mant;
  logic signed [10:0] w_sh;
  logic signed [10:0] w_rsh;
  logic [47:0]        w_mag;

  always_comb begin
    w_mant = {1'b1, i_flt[22:0]};
    // net binary-point shift of the 24-bit significand: exp - 127 - 23 + frac
    w_sh   = $signed({3'b000, i_flt[30:23]}) + $signed({5'b00000, i_frac}) - 11'sd150;
    w_rsh  = -w_sh;
    w_mag  = '0;
    o_fix  = '0;
    if (w_sh >= 11'sd24) begin
      // leading one would land at bit 47 or above
      o_fix = i_flt[31] ? 48'sh8000_0000_0000 : 48'sh7FFF_FFFF_FFFF;
    end else begin
      if (w_sh >= 11'sd0) w_mag = {24'd0, w_mant} << w_sh;
      else                w_mag = {24'd0, w_mant} >> w_rsh;
      o_fix = i_flt[31] ? -$signed(w_mag) : $signed(w_mag);
    end
  end
endmodule

module pvr_f2f_stage
  import pvr_f2f_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_valid,
  input  logic [2:0]       i_idx,
  input  logic [31:0]      i_flt,
  input  logic [5:0]       i_frac,
  output logic             o_valid,
  output logic [2:0]       o_tag,
  output logic [OUT_W-1:0] o_data,
  output logic             o_exc
);
  logic signed [47:0] w_conv;
  logic               r_valid;
  logic [2:0]         r_tag;
  logic signed [47:0] r_data;
  logic               r_special;
`ifdef PVR_F2F_CLAMP_EN
  logic               r_neg_inf;
  localparam logic signed [47:0] SAT_MAX = 48'sh7FFF_FFFF_FFFF >>> (48 - OUT_W);
  localparam logic signed [47:0] SAT_MIN = ~SAT_MAX;
`endif

  float_to_fixed u_cvt (
    .i_flt  (i_flt),
    .i_frac (i_frac),
    .o_fix  (w_conv)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_tag     <= '0;
      r_data    <= '0;
      r_special <= 1'b0;
`ifdef PVR_F2F_CLAMP_EN
      r_neg_inf <= 1'b0;
`endif
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_tag     <= i_idx;
        // zero and denormal inputs flush to exactly zero
        r_data    <= (i_flt[30:23] == EXP_ZERO) ? '0 : w_conv;
        r_special <= (i_flt[30:23] == EXP_SPECIAL);
`ifdef PVR_F2F_CLAMP_EN
        r_neg_inf <= (i_flt[30:23] == EXP_SPECIAL) && i_flt[31] && (i_flt[22:0] == '0);
`endif
      end
    end
  end

  assign o_valid = r_valid;
  assign o_tag   = r_tag;

`ifdef PVR_F2F_CLAMP_EN
  always_comb begin
    o_data = r_data[OUT_W-1:0];
    o_exc  = 1'b0;
    if (r_special) begin
      // NaN and +Inf go high, only -Inf goes low
      o_data = r_neg_inf ? SAT_MIN[OUT_W-1:0] : SAT_MAX[OUT_W-1:0];
      o_exc  = 1'b1;
    end else if (r_data > SAT_MAX) begin
      o_data = SAT_MAX[OUT_W-1:0];
      o_exc  = 1'b1;
    end else if (r_data < SAT_MIN) begin
      o_data = SAT_MIN[OUT_W-1:0];
      o_exc  = 1'b1;
    end
  end
`else
  always_comb begin
    o_data = r_data[OUT_W-1:0];
    o_exc  = r_special;
  end
`endif
endmodule

// File: rtl/pvr_vtx_f2f_seq.sv
// pvr_vtx_f2f_seq: converts one PVR vertex (X,Y,Z,U,V floats) to signed fixed
// point through one shared converter, one component per cycle.
//   clock, reset_n : clock, asynchronous active-low reset
//   bus (slave)    : vertex in / fixed vertex out handshake, out_exc, busy
// Parameters: FRAC_XY, FRAC_Z, FRAC_UV fraction bits; OUT_W output width (16..48).
// Optional: PVR_F2F_CLAMP_EN (see pvr_f2f_stage) saturates instead of truncating.
//
// state | meaning
// IDLE  | waiting for a vertex, in_ready=1
// CONV  | issuing component idx 0..4 to the converter
// DRAIN | writing back the last converted component
// DONE  | out_valid=1, holding results until out_ready
module pvr_vtx_f2f_seq
  import pvr_f2f_pkg::*;
#(
  parameter int FRAC_XY = 4,
  parameter int FRAC_Z  = 16,
  parameter int FRAC_UV = 8,
  parameter int OUT_W   = 32
) (
  input logic              clock,
  input logic              reset_n,
  pvr_vtx_f2f_seq_if.slave bus
);
  state_e           r_state, w_state_nxt;
  logic [2:0]       r_idx;
  logic [31:0]      r_flt  [5];
  logic [OUT_W-1:0] r_slot [5];
  logic [4:0]       r_exc;
  logic             r_out_valid;
  logic             w_in_ready, w_busy, w_accept;
  logic [31:0]      w_flt;
  logic             w_wb_valid, w_wb_exc;
  logic [2:0]       w_wb_tag;
  logic [OUT_W-1:0] w_wb_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = CONV;
      CONV:    if (r_idx == C_V)  w_state_nxt = DRAIN;
      DRAIN:                      w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == IDLE);
    w_busy     = (r_state != IDLE);
  end

  assign w_accept = w_in_ready && bus.in_valid;

  always_comb begin
    case (r_idx)
      C_X:     w_flt = r_flt[0];
      C_Y:     w_flt = r_flt[1];
      C_Z:     w_flt = r_flt[2];
      C_U:     w_flt = r_flt[3];
      default: w_flt = r_flt[4];
    endcase
  end

  pvr_f2f_stage #(.OUT_W(OUT_W)) u_stage (
    .clock   (clock),
    .reset_n (reset_n),
    .i_valid (r_state == CONV),
    .i_idx   (r_idx),
    .i_flt   (w_flt),
    .i_frac  (frac_for_idx(r_idx, 6'(FRAC_XY), 6'(FRAC_Z), 6'(FRAC_UV))),
    .o_valid (w_wb_valid),
    .o_tag   (w_wb_tag),
    .o_data  (w_wb_data),
    .o_exc   (w_wb_exc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx       <= C_X;
      r_exc       <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        r_flt[i]  <= '0;
        r_slot[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_flt[0] <= bus.in_x;
        r_flt[1] <= bus.in_y;
        r_flt[2] <= bus.in_z;
        r_flt[3] <= bus.in_u;
        r_flt[4] <= bus.in_v;
        for (int i = 0; i < 5; i++) r_slot[i] <= '0;
        r_exc <= '0;
        r_idx <= C_X;
      end else if (r_state == CONV && r_idx != C_V) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_wb_valid) begin
        r_slot[w_wb_tag] <= w_wb_data;
        if (w_wb_exc) r_exc[w_wb_tag] <= 1'b1;
      end
      if (r_state == DRAIN)                    r_out_valid <= 1'b1;
      else if (r_state == DONE && bus.out_ready) r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_x     = r_slot[0];
  assign bus.out_y     = r_slot[1];
  assign bus.out_z     = r_slot[2];
  assign bus.out_u     = r_slot[3];
  assign bus.out_v     = r_slot[4];
  assign bus.out_exc   = r_exc;
endmodule

// File: tb/tb_pvr_vtx_f2f_seq.sv
module tb_pvr_vtx_f2f_seq;
  typedef struct packed {
    logic [4:0][31:0] f;    // inputs X..V (index 0 = X)
    logic [4:0][31:0] val;  // expected fixed results
    logic [4:0]       mask; // which result values are checked
    logic [4:0]       exc;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc = 0;
  logic prev_ov = 1'b0;
  vec_t sb[$];
  vec_t tbl[5];

  pvr_vtx_f2f_seq_if #(.OUT_W(32)) bus ();

  pvr_vtx_f2f_seq #(.FRAC_XY(4), .FRAC_Z(16), .FRAC_UV(8), .OUT_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] x, y, z, u, v,
                              input logic [31:0] ex, ey, ez, eu, ev,
                              input logic [4:0] mask, input logic [4:0] exc);
    vec_t t;
    t.f    = {v, u, z, y, x};
    t.val  = {ev, eu, ez, ey, ex};
    t.mask = mask;
    t.exc  = exc;
    return t;
  endfunction

  // scoreboard: compare on every output handshake, and latency on out_valid rise
  always @(negedge clock) begin
    logic [4:0][31:0] act;
    vec_t e;
    if (reset_n) begin
      if (bus.out_valid && !prev_ov) chk("latency", 32'(cyc - acc), 32'd6);
      if (bus.out_valid && bus.out_ready) begin
        act = {bus.out_v, bus.out_u, bus.out_z, bus.out_y, bus.out_x};
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          for (int i = 0; i < 5; i++)
            if (e.mask[i]) chk($sformatf("out_slot%0d", i), act[i], e.val[i]);
          chk("out_exc", 32'(bus.out_exc), 32'(e.exc));
        end
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic send(input vec_t v, input bit push);
    int n = 0;
    @(posedge clock); #1;
    bus.in_valid = 1'b1;
    bus.in_x = v.f[0]; bus.in_y = v.f[1]; bus.in_z = v.f[2];
    bus.in_u = v.f[3]; bus.in_v = v.f[4];
    @(negedge clock);
    while (!bus.in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    acc = cyc;
    bus.in_valid = 1'b0;
    if (push) sb.push_back(v);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    tbl[0] = mk(32'h3F800000, 32'hC0200000, 32'h3F000000, 32'h3F000000, 32'h00000000,
                32'h00000010, 32'hFFFFFFD8, 32'h00008000, 32'h00000080, 32'h00000000,
                5'b11111, 5'b00000);
    tbl[1] = mk(32'h00000001, 32'h80000000, 32'h40400000, 32'hBF800000, 32'h42C80000,
                32'h00000000, 32'h00000000, 32'h00030000, 32'hFFFFFF00, 32'h00006400,
                5'b11111, 5'b00000);
`ifdef PVR_F2F_CLAMP_EN
    tbl[2] = mk(32'h3DCCCCCD, 32'hBDCCCCCD, 32'h7F800000, 32'h3F800000, 32'hBF000000,
                32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000100, 32'hFFFFFF80,
                5'b11111, 5'b00100);
    tbl[3] = mk(32'hC2F60000, 32'h44800000, 32'h47800000, 32'h00400000, 32'hFF800000,
                32'hFFFFF850, 32'h00004000, 32'h7FFFFFFF, 32'h00000000, 32'h80000000,
                5'b11111, 5'b10100);
    tbl[4] = mk(32'hCF000000, 32'h4B000000, 32'h3F800000, 32'h7FC00000, 32'h00000000,
                32'h80000000, 32'h08000000, 32'h00010000, 32'h7FFFFFFF, 32'h00000000,
                5'b11111, 5'b01001);
`else
    tbl[2] = mk(32'h3DCCCCCD, 32'hBDCCCCCD, 32'h7F800000, 32'h3F800000, 32'hBF000000,
                32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h00000100, 32'hFFFFFF80,
                5'b11011, 5'b00100);
    tbl[3] = mk(32'hC2F60000, 32'h44800000, 32'h47800000, 32'h00400000, 32'hFF800000,
                32'hFFFFF850, 32'h00004000, 32'h00000000, 32'h00000000, 32'h00000000,
                5'b01111, 5'b10000);
    tbl[4] = mk(32'hCF000000, 32'h4B000000, 32'h3F800000, 32'h7FC00000, 32'h00000000,
                32'h00000000, 32'h08000000, 32'h00010000, 32'h00000000, 32'h00000000,
                5'b10111, 5'b01000);
`endif

    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.in_x = '0; bus.in_y = '0; bus.in_z = '0; bus.in_u = '0; bus.in_v = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_x", bus.out_x, 32'd0);
    chk("rst_out_v", bus.out_v, 32'd0);
    chk("rst_out_exc", 32'(bus.out_exc), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // table vectors with out_ready held high
    for (int i = 0; i < 5; i++) begin
      send(tbl[i], 1'b1);
      wait_drain();
    end

    // backpressure: hold out_ready low for 10 cycles in DONE
    bus.out_ready = 1'b0;
    send(tbl[0], 1'b1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
    repeat (10) begin
      @(negedge clock);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_x", bus.out_x, tbl[0].val[0]);
      chk("bp_hold_y", bus.out_y, tbl[0].val[1]);
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    wait_drain();

    // reset while CONV is presenting idx=2; vertex must vanish
    send(tbl[2], 1'b0);
    @(posedge clock);
    @(posedge clock); #1;
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_exc", 32'(bus.out_exc), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("mid_no_output", 32'(bus.out_valid), 32'd0);
    send(tbl[1], 1'b1);
    wait_drain();
    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
